// File: rtl/spsram_arbiter.sv
// Shares one single-ported, 1-cycle-read SRAM between NUM_PORTS requesters: one access per cycle, optional lock bursts.
// Round-robin by default; define SPSRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority (lock still overrides).
module spsram_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            lock,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            ack,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic                            sram_we,
    output logic [DATA_WIDTH-1:0]           sram_wdata,
    input  logic [DATA_WIDTH-1:0]           sram_q
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [IDX_W-1:0]     lock_owner;
    logic                 lock_valid;
    logic [NUM_PORTS-1:0] pending;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 grant_lock;
    logic                 owner_req;
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_ptr;
`endif

    // Is the current lock owner still requesting?
    always_comb begin
        owner_req = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (lock_owner == IDX_W'(i)) owner_req = req[i];
        end
    end

    // Grant selection: live lock owner first, otherwise priority search.
    always_comb begin
        int unsigned cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (!reset) begin
            if (lock_valid && owner_req) begin
                grant_valid = 1'b1;
                grant_idx   = lock_owner;
            end else begin
`ifdef SPSRAM_ARB_FIXED_PRIO_EN
                for (int unsigned i = NUM_PORTS; i > 0; i--) begin
                    if (req[i-1]) begin
                        grant_valid = 1'b1;
                        grant_idx   = IDX_W'(i - 1);
                    end
                end
`else
                // Descending scan so the nearest port after rr_ptr is the last (winning) assignment.
                for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
                    cand = (32'(rr_ptr) + k) % NUM_PORTS;
                    if (req[cand]) begin
                        grant_valid = 1'b1;
                        grant_idx   = IDX_W'(cand);
                    end
                end
`endif
            end
        end
    end

    // SRAM port mux; idles on port 0 operands with the write enable forced low.
    always_comb begin
        sram_addr  = addr[0 +: ADDR_WIDTH];
        sram_wdata = wdata[0 +: DATA_WIDTH];
        sram_we    = 1'b0;
        grant_lock = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sram_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sram_we    = grant_valid & we[i];
                grant_lock = lock[i];
            end
        end
    end

    assign ack    = grant_valid ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign rvalid = pending;
    assign rdata  = sram_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
            rr_ptr     <= IDX_W'(NUM_PORTS - 1);
`endif
            lock_valid <= 1'b0;
            lock_owner <= '0;
            pending    <= '0;
        end else begin
            pending <= (grant_valid && !sram_we) ? ack : '0;
            if (grant_valid) begin
`ifndef SPSRAM_ARB_FIXED_PRIO_EN
                rr_ptr     <= grant_idx;
`endif
                lock_valid <= grant_lock;
                lock_owner <= grant_idx;
            end else if (lock_valid && !owner_req) begin
                lock_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spsram_arbiter.sv
// Self-checking bench for spsram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_spsram_arbiter;

    localparam int NP = 2;
    localparam int AW = 12;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     req, lock, we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     ack, rvalid;
    logic [DW-1:0]     rdata, sram_wdata, sram_q;
    logic [AW-1:0]     sram_addr;
    logic              sram_we;

    spsram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rvalid(rvalid), .rdata(rdata), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // SRAM behaviour: registered read-first output, cleared while reset is high.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            sram_q <= '0;
        end else begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            sram_q <= mem[sram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the current cycle
    logic          t_rst;
    logic [NP-1:0] t_req, t_lock, t_we;
    logic [AW-1:0] t_addr [NP];
    logic [DW-1:0] t_wdata [NP];

    // Reference model state
    int            m_ptr, m_owner, m_pend, m_g;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_mem [0:(1<<AW)-1];

    logic [NP-1:0] exp_ack, exp_rvalid;
    logic [DW-1:0] exp_rdata, exp_wdata;
    logic [AW-1:0] exp_addr;
    logic          exp_we;

    task automatic set_port(input int p, input logic r, input logic l, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_req[p] = r; t_lock[p] = l; t_we[p] = w; t_addr[p] = a; t_wdata[p] = d;
    endtask

    // Drive this cycle's inputs and compute what the arbiter should present.
    task automatic eval_cycle();
        int g;
        reset = t_rst; req = t_req; lock = t_lock; we = t_we;
        for (int p = 0; p < NP; p++) begin
            addr[p*AW +: AW]  = t_addr[p];
            wdata[p*DW +: DW] = t_wdata[p];
        end
        if (t_rst) begin
            m_ptr = NP - 1; m_owner = -1; m_pend = -1;
            for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
        end
        #1;
        g = -1;
        if (!t_rst) begin
            if (m_owner >= 0 && t_req[m_owner]) g = m_owner;
            else begin
`ifdef SPSRAM_ARB_FIXED_PRIO_EN
                for (int k = 0; k < NP; k++) if (g < 0 && t_req[k]) g = k;
`else
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (m_ptr + k) % NP;
                    if (g < 0 && t_req[p]) g = p;
                end
`endif
            end
        end
        m_g = g;
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        exp_rvalid = '0;
        if (m_pend >= 0) exp_rvalid[m_pend] = 1'b1;
        exp_rdata = m_pend_data;
        exp_we    = (g >= 0) ? t_we[g] : 1'b0;
        exp_addr  = (g >= 0) ? t_addr[g] : t_addr[0];
        exp_wdata = (g >= 0) ? t_wdata[g] : t_wdata[0];
    endtask

    // Apply the cycle's effects to the model, then move to the next drive point.
    task automatic finish_cycle();
        if (!t_rst && m_g >= 0) begin
            if (t_we[m_g]) begin
                m_mem[t_addr[m_g]] = t_wdata[m_g];
                m_pend = -1;
            end else begin
                m_pend      = m_g;
                m_pend_data = m_mem[t_addr[m_g]];
            end
            m_ptr   = m_g;
            m_owner = t_lock[m_g] ? m_g : -1;
        end else begin
            m_pend = -1;
            if (m_owner >= 0 && !t_req[m_owner]) m_owner = -1;
        end
        @(negedge clk);
    endtask

    task automatic idle_ports();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle_ports();
        t_rst = 1'b1;
        eval_cycle(); finish_cycle();
        eval_cycle(); finish_cycle();
        t_rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_ports();
        t_rst = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b1, 12'h011, 16'h1111);
        set_port(1, 1'b1, 1'b1, 1'b1, 12'h022, 16'h2222);
        for (int c = 0; c < 2; c++) begin
            eval_cycle();
            n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack cyc=%0d got=%b exp=00", c, ack); end
            n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid cyc=%0d got=%b exp=00", c, rvalid); end
            n_checks++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_sram_we cyc=%0d got=%b exp=0", c, sram_we); end
            finish_cycle();
        end
        t_rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, 12'h010, 16'hBEEF);
        eval_cycle();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL single_wr_ack got=%b exp=01", ack); end
        n_checks++; if (sram_we !== 1'b1 || sram_addr !== 12'h010 || sram_wdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL single_wr_bus got=%b/%h/%h exp=1/010/beef", sram_we, sram_addr, sram_wdata); end
        finish_cycle();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
        eval_cycle();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL single_rd_ack got=%b exp=01", ack); end
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_wr_norvalid got=%b exp=00", rvalid); end
        finish_cycle();
        idle_ports();
        eval_cycle();
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL single_rvalid got=%b exp=01", rvalid); end
        n_checks++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL single_rdata got=%h exp=beef", rdata); end
        finish_cycle();
        eval_cycle();
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_rvalid_clear got=%b exp=00", rvalid); end
        finish_cycle();
    endtask

    task automatic test_contention();
        logic [NP-1:0] exp_a, prev_a;
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, 12'h001, 16'hA001);
        eval_cycle(); finish_cycle();
        idle_ports();
        set_port(1, 1'b1, 1'b0, 1'b1, 12'h002, 16'hB002);
        eval_cycle(); finish_cycle();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000);
        set_port(1, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0000);
        prev_a = 2'b00;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) idle_ports();
`ifdef SPSRAM_ARB_FIXED_PRIO_EN
            exp_a = (c == 6) ? 2'b00 : 2'b01;
`else
            exp_a = (c == 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
`endif
            eval_cycle();
            n_checks++; if (ack !== exp_a) begin n_fail++; $display("FAIL contention_ack cyc=%0d got=%b exp=%b", c, ack, exp_a); end
            n_checks++; if (rvalid !== prev_a) begin n_fail++; $display("FAIL contention_rvalid cyc=%0d got=%b exp=%b", c, rvalid, prev_a); end
            if (c > 0) begin
                n_checks++;
                if (rdata !== ((prev_a == 2'b01) ? 16'hA001 : 16'hB002)) begin
                    n_fail++; $display("FAIL contention_rdata cyc=%0d got=%h tag=%b", c, rdata, prev_a); end
            end
            prev_a = exp_a;
            finish_cycle();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h0FF, 16'h0000);
        set_port(1, 1'b1, 1'b0, 1'b1, 12'h0FF, 16'h1234);
        eval_cycle();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL wr_rd_ack0 got=%b exp=01", ack); end
        finish_cycle();
        set_port(0, 1'b0, 1'b0, 1'b0, 12'h0FF, 16'h0000);
        eval_cycle();
        n_checks++; if (ack !== 2'b10 || sram_we !== 1'b1) begin n_fail++; $display("FAIL wr_rd_ack1 got=%b/%b exp=10/1", ack, sram_we); end
        n_checks++; if (rvalid !== 2'b01 || rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rd_old got=%b/%h exp=01/0000", rvalid, rdata); end
        finish_cycle();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h0FF, 16'h0000);
        set_port(1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        eval_cycle();
        n_checks++; if (ack !== 2'b01 || rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_rd_ack2 got=%b/%b exp=01/00", ack, rvalid); end
        finish_cycle();
        idle_ports();
        eval_cycle();
        n_checks++; if (rvalid !== 2'b01 || rdata !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_new got=%b/%h exp=01/1234", rvalid, rdata); end
        finish_cycle();
    endtask

    task automatic test_lock_burst();
        logic [NP-1:0] exp_a;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_port(1, c < 5, c < 3, 1'b0, 12'h020 + 12'(c), 16'h0000);
            set_port(0, (c >= 1) && (c < 5), 1'b0, 1'b0, 12'h005, 16'h0000);
            exp_a = (c < 4) ? 2'b10 : ((c == 4) ? 2'b01 : 2'b00);
            eval_cycle();
            n_checks++; if (ack !== exp_a) begin n_fail++; $display("FAIL lock_ack cyc=%0d got=%b exp=%b", c, ack, exp_a); end
            n_checks++;
            if (rvalid !== ((c == 0) ? 2'b00 : ((c == 5) ? 2'b01 : 2'b10))) begin
                n_fail++; $display("FAIL lock_rvalid cyc=%0d got=%b", c, rvalid); end
            finish_cycle();
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_port(1, 1'b1, 1'b1, 1'b0, 12'h003, 16'h0000);
        eval_cycle();
        n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL midrst_ack got=%b exp=10", ack); end
        finish_cycle();
        set_port(0, 1'b1, 1'b0, 1'b0, 12'h004, 16'h0000);
        t_rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            eval_cycle();
            n_checks++; if (rvalid !== 2'b00 || ack !== 2'b00) begin
                n_fail++; $display("FAIL midrst_hold cyc=%0d got=%b/%b exp=00/00", c, rvalid, ack); end
            finish_cycle();
        end
        t_rst = 1'b0;
        eval_cycle();
        n_checks++; if (ack !== 2'b01 || rvalid !== 2'b00) begin n_fail++; $display("FAIL midrst_after got=%b/%b exp=01/00", ack, rvalid); end
        finish_cycle();
    endtask

    task automatic test_random();
        logic active [NP];
        do_reset();
        for (int p = 0; p < NP; p++) active[p] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!active[p]) begin
                    active[p] = ($urandom_range(0, 3) != 0);
                    set_port(p, active[p], ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                             12'($urandom_range(0, 15)), 16'($urandom));
                end
            end
            eval_cycle();
            n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, ack, exp_ack); end
            n_checks++; if (rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_rvalid); end
            if (exp_rvalid != 0) begin
                n_checks++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, rdata, exp_rdata); end
            end
            n_checks++; if (sram_we !== exp_we) begin n_fail++; $display("FAIL rand_sram_we cyc=%0d got=%b exp=%b", c, sram_we, exp_we); end
            if (exp_ack != 0) begin
                n_checks++; if (sram_addr !== exp_addr) begin n_fail++; $display("FAIL rand_sram_addr cyc=%0d got=%h exp=%h", c, sram_addr, exp_addr); end
                n_checks++; if (sram_wdata !== exp_wdata) begin n_fail++; $display("FAIL rand_sram_wdata cyc=%0d got=%h exp=%h", c, sram_wdata, exp_wdata); end
            end
            if (m_g >= 0) active[m_g] = 1'b0;
            finish_cycle();
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        t_rst = 1'b1;
        idle_ports();
        m_ptr = NP - 1; m_owner = -1; m_pend = -1; m_g = -1; m_pend_data = '0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_lock_burst();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spsram_arbiter.md
Name: spsram_arbiter

Overview:
- Shares one single-ported SRAM (1 read/write port, 1-cycle registered read) between NUM_PORTS requesters.
- Round-robin arbitration, one access issued per cycle, read data returned one cycle after issue with a per-port valid strobe.
- Optional lock lets one requester hold the port for back-to-back bursts.
- Sits between CPU/DMA-style masters and the shared SRAM instance.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 16, SRAM data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port access request, held until acked.
- lock  in  NUM_PORTS  per-port request to keep the grant after this access.
- we  in  NUM_PORTS  per-port write enable; 0 = read.
- addr  in  NUM_PORTS*ADDR_WIDTH  flat address bus; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_PORTS*DATA_WIDTH  flat write-data bus, same packing.
- ack  out  NUM_PORTS  one-hot; access accepted this cycle (combinational).
- rvalid  out  NUM_PORTS  one-hot; rdata valid for that port this cycle.
- rdata  out  DATA_WIDTH  shared return data (= sram_q).
- sram_addr  out  ADDR_WIDTH  to SRAM address.
- sram_we  out  1  to SRAM write enable.
- sram_wdata  out  DATA_WIDTH  to SRAM write data.
- sram_q  in  DATA_WIDTH  from SRAM registered output.

Behaviour:
- Reset values:
  - ack = 0, rvalid = 0, sram_we = 0.
  - sram_addr and sram_wdata follow the port-0 mux, don't-care.
  - Round-robin pointer = NUM_PORTS-1, so port 0 has first priority.
  - Lock owner cleared; pending-read register cleared.
- Arbitration, combinational each cycle:
  - Lock owner valid and its req high: grant owner.
  - Otherwise: grant the first requesting port searching upward from pointer+1, wrapping modulo NUM_PORTS.
  - No req: no grant; sram_we = 0.
- Issue:
  - Granted port g sees ack[g] = 1.
  - sram_addr, sram_we and sram_wdata are driven from port g in the same cycle.
  - The SRAM latches them at the next rising edge.
- Pointer: on each grant, pointer <= g.
- Lock state:
  - Lock owner <= g when lock[g] = 1 at grant.
  - Lock owner cleared when the owner is granted with lock = 0, or the owner drops req.
  - If the owner drops req, normal round-robin resumes in that same cycle.
- Read return:
  - A granted read (we = 0) sets pending <= one-hot(g).
  - Next cycle, rvalid = pending and rdata = sram_q (latency 1 from ack).
  - Writes produce no rvalid; the SRAM's write-through q is ignored.
- Throughput:
  - One access per cycle, back-to-back allowed.
  - rvalid of access N coincides with ack of access N+1.
- Ports not acked keep req and their operands stable; the arbiter does not queue.
- Simultaneous req from all ports, no lock: grants rotate 0,1,...,NUM_PORTS-1,0 on consecutive cycles.
- Reset asserted mid-operation:
  - Any pending rvalid is dropped (rvalid = 0 next cycle).
  - Lock is cleared; the pointer returns to its reset value.
- A port changing we/addr while not acked has no effect.

Optional Feature:
- Macro: SPSRAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Round-robin pointer is removed; lowest-index requesting port always wins.
  - Lock still overrides priority.
- Undefined: round-robin as above.

Test Plan:
- Single read: port 0 reads addr 0x010 after a prior write of 0xBEEF -> ack[0] in cycle T, rvalid[0] = 1 with rdata = 0xBEEF in T+1, no other rvalid.
- Contention: ports 0 and 1 both request continuously, reads of 0x001 and 0x002 -> acks alternate 0,1,0,1; each rvalid one cycle after its ack, tagged to the correct port.
- Write then read same cycle pair: port 1 writes 0x1234 to 0x0FF with port 0 reading 0x0FF waiting -> port 0 (first priority after reset) acked first gets old data 0x0000; a subsequent read returns 0x1234.
- Lock burst: port 1 asserts lock for 4 reads while port 0 requests -> port 1 acked 4 consecutive cycles; port 0 acked the cycle after port 1's final access with lock = 0.
- Reset mid-read: assert reset the cycle after a read ack -> rvalid stays 0; after release, port 0 wins first.
- With SPSRAM_ARB_FIXED_PRIO_EN, ports 0 and 1 requesting continuously -> port 0 acked every cycle, port 1 never acked until port 0 drops req.
